// File: rtl/imem_prefetch_buffer.sv
// -----------------------------------------------------------------------------
// imem_prefetch_buffer
//
// Instruction prefetch queue that sits between instruction memory and the
// core's fetch stage. It runs ahead sequentially from the current fetch PC and
// issues word requests over a valid/ready port. It keeps in-order responses in
// a small ring and hands the head word to the core while the core's PC matches
// the head address. A PC that differs from the head address is a redirect. On a
// redirect the queue is flushed and responses that are still in flight are
// thrown away.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous reset, active low
//   pc_req         fetch PC from the core (PCF); bits [1:0] are ignored
//   stall          core StallF; while high no queue entry is consumed
//   instr          instruction for pc_req, or NOP_INSTR on a miss
//   instr_valid    instr carries memory data for pc_req
//   miss_stall     inverse of instr_valid; the core must hold PCF
//   mem_req_valid  fetch request valid
//   mem_req_ready  memory accepts the request
//   mem_addr       word-aligned fetch address
//   mem_rsp_valid  response valid (in order, never before its request)
//   mem_rsp_data   response instruction word
// -----------------------------------------------------------------------------
module imem_prefetch_buffer #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR       = 32'hE1A0_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_req,
  input  logic        stall,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        miss_stall,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  // Wide enough for count + outstanding (outstanding never exceeds DEPTH).
  localparam int SUM_W = CNT_W + 1;

  logic [31:0]      head_pc_reg;
  logic [31:0]      fetch_addr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [OUT_W-1:0] outstanding_reg;
  logic [OUT_W-1:0] discard_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [31:0]      ring_mem [DEPTH];

  logic [31:0]      pc;
  logic             redirect;
  logic             hit;
  logic             issue;
  logic             push;
  logic             pop;
  logic [SUM_W-1:0] occupancy;
  logic [OUT_W-1:0] outstanding_after_rsp;
  logic             unused_pc_bits;

  assign pc             = {pc_req[31:2], 2'b00};
  assign unused_pc_bits = ^pc_req[1:0];

  assign redirect = (pc != head_pc_reg);
  assign hit      = (count_reg != '0) && !redirect;

  assign instr       = hit ? ring_mem[rd_ptr_reg] : NOP_INSTR;
  assign instr_valid = hit;
  assign miss_stall  = !hit;

  // A request may only be issued when it is certain to find a ring slot on
  // return. Slots are reserved by counting in-flight requests in the occupancy.
  assign occupancy     = SUM_W'(count_reg) + SUM_W'(outstanding_reg);
  assign mem_req_valid = reset && !redirect
                         && (occupancy < SUM_W'(DEPTH))
                         && (outstanding_reg < OUT_W'(MAX_OUTSTANDING));
  assign mem_addr      = fetch_addr_reg;
  assign issue         = mem_req_valid && mem_req_ready;

  // Responses that belong to an older instruction stream are dropped. These
  // are counted in discard, or the response arrives on the redirect edge itself.
  assign push = mem_rsp_valid && (discard_reg == '0) && !redirect;
  assign pop  = hit && !stall;

  assign outstanding_after_rsp = outstanding_reg - OUT_W'(mem_rsp_valid);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_pc_reg     <= RESET_PC;
      fetch_addr_reg  <= RESET_PC;
      count_reg       <= '0;
      outstanding_reg <= '0;
      discard_reg     <= '0;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
    end else if (redirect) begin
      // Flush the queue and restart at the new PC. Every request still in
      // flight after this edge is stale and must be discarded.
      head_pc_reg     <= pc;
      fetch_addr_reg  <= pc;
      count_reg       <= '0;
      rd_ptr_reg      <= wr_ptr_reg;
      outstanding_reg <= outstanding_after_rsp;
      discard_reg     <= outstanding_after_rsp;
    end else begin
      if (issue) begin
        fetch_addr_reg <= fetch_addr_reg + 32'd4;
      end
      outstanding_reg <= outstanding_after_rsp + OUT_W'(issue);
      if (mem_rsp_valid && (discard_reg != '0)) begin
        discard_reg <= discard_reg - OUT_W'(1);
      end
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg  <= rd_ptr_reg + PTR_W'(1);
        head_pc_reg <= head_pc_reg + 32'd4;
      end
      unique case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // The data ring has no reset. A slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      ring_mem[wr_ptr_reg] <= mem_rsp_data;
    end
  end

endmodule

// File: tb/tb_imem_prefetch_buffer.sv
// -----------------------------------------------------------------------------
// tb_imem_prefetch_buffer
//
// Random stimulus against a queue-level reference model of the prefetcher.
// The model keeps the words in a queue of expected instructions. In-flight
// requests are tagged with a stream generation number, so a redirect makes
// every older tag stale. The memory is a separate in-order model with random
// latency that returns 0xA0 + address.
// -----------------------------------------------------------------------------
module tb_imem_prefetch_buffer;

  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;
  localparam logic [31:0] NOP   = 32'hE1A0_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc_req = '0;
  logic        stall = 1'b0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        miss_stall;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;

  always #5 clk = ~clk;

  imem_prefetch_buffer #(
    .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO),
    .RESET_PC(32'h0), .NOP_INSTR(NOP)
  ) dut (
    .clk(clk), .reset(reset), .pc_req(pc_req), .stall(stall),
    .instr(instr), .instr_valid(instr_valid), .miss_stall(miss_stall),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] addr;
    int          gen;
  } tag_t;

  typedef struct {
    logic [31:0] addr;
    int          ready;
  } mreq_t;

  logic [31:0] m_q[$];      // expected queued instruction words, oldest first
  tag_t        m_tags[$];   // expected in-flight requests
  logic [31:0] m_head;
  logic [31:0] m_fetch;
  int          m_gen;
  mreq_t       mem_pend[$]; // memory model: accepted, unanswered requests
  logic [31:0] core_pc;
  int          cyc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA0 + a;
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_tags.delete();
    mem_pend.delete();
    m_head  = '0;
    m_fetch = '0;
    m_gen   = 0;
    core_pc = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset         = 1'b0;
    stall         = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    pc_req        = '0;
    #1;
    check_eq("rst_req_valid", mem_req_valid, 0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_instr", instr, NOP);
    check_eq("rst_instr_valid", instr_valid, 0);
    check_eq("rst_miss_stall", miss_stall, 1);
    model_clear();
    @(negedge clk);
    check_eq("rst_hold_req_valid", mem_req_valid, 0);
    reset = 1'b1;
    #1;
    check_eq("rst_release_req_valid", mem_req_valid, 1);
    $display("reset released");
  endtask

  task automatic run_cycle(input int p_stall, input int p_ready, input int p_rsp,
                           input int p_redir, input int max_lat);
    logic        redir;
    logic        hit;
    logic        exp_req;
    logic [31:0] exp_instr;
    tag_t        t;
    @(negedge clk);
    cyc++;
    if ($urandom_range(0, 99) < p_redir) begin
      if ($urandom_range(0, 9) == 0) core_pc = 32'hFFFF_FFF8;
      else core_pc = 32'($urandom_range(0, 255)) << 2;
    end
    pc_req        = core_pc | 32'($urandom_range(0, 3));
    stall         = ($urandom_range(0, 99) < p_stall);
    mem_req_ready = ($urandom_range(0, 99) < p_ready);
    if (mem_pend.size() > 0 && mem_pend[0].ready <= cyc &&
        $urandom_range(0, 99) < p_rsp) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mem_word(mem_pend[0].addr);
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = $urandom;
    end
    #1;
    redir     = (core_pc != m_head);
    hit       = (m_q.size() != 0) && !redir;
    exp_instr = hit ? m_q[0] : NOP;
    exp_req   = !redir && (m_q.size() + m_tags.size() < DEPTH) && (m_tags.size() < MAXO);
    check_eq("instr", instr, exp_instr);
    check_eq("instr_valid", instr_valid, hit);
    check_eq("miss_stall", miss_stall, !hit);
    check_eq("mem_req_valid", mem_req_valid, exp_req);
    check_eq("mem_addr", mem_addr, m_fetch);

    // Response: a word is kept only if it belongs to the current stream and
    // no redirect happens on this edge.
    if (mem_rsp_valid) begin
      void'(mem_pend.pop_front());
      if (m_tags.size() > 0) begin
        t = m_tags.pop_front();
        if (t.gen == m_gen && !redir) m_q.push_back(mem_word(t.addr));
      end
    end
    if (redir) begin
      m_q.delete();
      m_head  = core_pc;
      m_fetch = core_pc;
      m_gen++;
    end else begin
      if (hit && !stall) begin
        $display("consume pc=%h instr=%h", m_head, exp_instr);
        void'(m_q.pop_front());
        m_head  = m_head + 32'd4;
        core_pc = core_pc + 32'd4;
      end
      if (exp_req && mem_req_ready) begin
        m_tags.push_back('{addr: m_fetch, gen: m_gen});
        m_fetch = m_fetch + 32'd4;
      end
    end
    // The memory model follows the DUT's real handshake, so a wrong address
    // shows up as a wrong data word as well.
    if (mem_req_valid && mem_req_ready)
      mem_pend.push_back('{addr: mem_addr, ready: cyc + 1 + int'($urandom_range(0, max_lat - 1))});
  endtask

  initial begin
    cyc = 0;
    model_clear();
    do_reset();

    // Start-up latency: 1-cycle memory and no stalls. The first word appears
    // two cycles after its request, and then one word follows per cycle.
    for (int i = 0; i < 8; i++) begin
      run_cycle(0, 100, 100, 0, 1);
      if (i == 2) check_eq("lat_first_instr", instr, 32'hA0);
      if (i == 3) check_eq("lat_second_instr", instr, 32'hA4);
      if (i == 4) check_eq("lat_third_instr", instr, 32'hA8);
      if (i >= 2) check_eq("lat_sustained_valid", instr_valid, 1);
    end

    // Queue fill under a long stall, then drain.
    for (int i = 0; i < 10; i++) run_cycle(100, 100, 100, 0, 1);
    check_eq("fill_req_blocked", mem_req_valid, 0);
    check_eq("fill_head_valid", instr_valid, 1);
    for (int i = 0; i < 4; i++) begin
      run_cycle(0, 0, 100, 0, 1);
      check_eq("drain_hit", instr_valid, 1);
    end

    // Memory refusing requests: the address holds and no data arrives.
    for (int i = 0; i < 6; i++) run_cycle(0, 0, 100, 0, 1);
    check_eq("ready_low_miss", miss_stall, 1);

    // Randomized rounds with occasional mid-stream resets.
    for (int r = 0; r < 40; r++) begin
      int ps, pr, pp, pd, ml;
      ps = $urandom_range(0, 60);
      pr = $urandom_range(20, 100);
      pp = $urandom_range(30, 100);
      pd = $urandom_range(0, 15);
      ml = $urandom_range(1, 4);
      for (int i = 0; i < 40; i++) run_cycle(ps, pr, pp, pd, ml);
      if ($urandom_range(0, 4) == 0) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
